// File: rtl/modulator_pkg.sv
// rtl/modulator_pkg.sv - shared constants and types for the polar to I/Q modulator
// Contents:
//   state_e   : FSM states IDLE / PRESCALE / ROTATE
//   INV_K     : 1/K CORDIC gain compensation, 0.60725 * 2^15
//   ATAN_LUT  : atan(2^-i) in 16-bit phase units (2^16 = 2*pi), rounded
package modulator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESCALE,
        ROTATE
    } state_e;

    localparam int INV_K = 19898;

    localparam int ATAN_LUT [0:14] = '{
        8192, 4836, 2555, 1297, 651, 326, 163, 81,
        41, 20, 10, 5, 3, 1, 1
    };

endpackage

// File: rtl/cordic_microrot.sv
// rtl/cordic_microrot.sv - one combinational CORDIC rotation-mode step
// Ports:
//   x_i, y_i  : current vector (signed XW)
//   z_i       : residual angle (signed ZW)
//   i_i       : step index, shift amount
//   atan_i    : atan(2^-i) for this step
//   x_o, y_o, z_o : updated vector and residual angle
module cordic_microrot #(
    parameter int XW = 15,
    parameter int ZW = 17,
    parameter int IW = 4
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [IW-1:0] i_i,
    input  logic signed [ZW-1:0] atan_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic                 rot_pos;

    assign x_sh    = x_i >>> i_i;
    assign y_sh    = y_i >>> i_i;
    // Residual angle non-negative: rotate counter-clockwise to drive it toward zero.
    assign rot_pos = ~z_i[ZW-1];

    assign x_o = rot_pos ? (x_i - y_sh)   : (x_i + y_sh);
    assign y_o = rot_pos ? (y_i + x_sh)   : (y_i - x_sh);
    assign z_o = rot_pos ? (z_i - atan_i) : (z_i + atan_i);

endmodule

// File: rtl/polar_iq_modulator.sv
// rtl/polar_iq_modulator.sv - polar (magnitude, phase) to signed I/Q via iterative CORDIC
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, accepted only while idle
//   magnitude, phase  : polar input, phase full scale 2^PHASE_W = 2*pi
//   i_out, q_out      : signed rounded, saturated I/Q result, held between results
//   busy              : computation in flight
//   valid             : one-cycle pulse when i_out/q_out update
module polar_iq_modulator
    import modulator_pkg::*;
#(
    parameter int MAG_W   = 9,
    parameter int PHASE_W = 16,
    parameter int ITER    = 12,
    parameter int GUARD   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic        [MAG_W-1:0]   magnitude,
    input  logic        [PHASE_W-1:0] phase,
    output logic signed [MAG_W:0]     i_out,
    output logic signed [MAG_W:0]     q_out,
    output logic                      busy,
    output logic                      valid
);

    localparam int XW = MAG_W + GUARD + 2;
    localparam int ZW = PHASE_W + 1;
    localparam int IW = 4;
    localparam int PW = MAG_W + 15;

    state_e                state_q;
    logic [MAG_W-1:0]      mag_q;
    logic [PHASE_W-1:0]    phase_q;
    logic signed [XW-1:0]  x_q, y_q;
    logic signed [ZW-1:0]  z_q;
    logic [IW-1:0]         iter_q;
    logic signed [MAG_W:0] i_out_q, q_out_q;
    logic                  busy_q, valid_q;

    logic [PW-1:0]         prod;
    logic signed [XW-1:0]  m_s;
    logic signed [ZW-1:0]  atan_cur;
    logic signed [XW-1:0]  x_d, y_d;
    logic signed [ZW-1:0]  z_d;

    // Pre-divide by the CORDIC gain so the rotated vector lands at the true magnitude.
    assign prod     = PW'(mag_q) * PW'(INV_K);
    assign m_s      = XW'(prod >> (15 - GUARD));
    assign atan_cur = ZW'(ATAN_LUT[iter_q]);

    cordic_microrot #(.XW(XW), .ZW(ZW), .IW(IW)) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .i_i    (iter_q),
        .atan_i (atan_cur),
        .x_o    (x_d),
        .y_o    (y_d),
        .z_o    (z_d)
    );

    // Drop guard bits with round-half-up, then clamp to +/-(2^MAG_W - 1).
    function automatic logic signed [MAG_W:0] round_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] ext;
        logic signed [XW:0] half;
        logic signed [XW:0] r;
        logic signed [XW:0] lim;
        ext  = (XW+1)'(v);
        half = (XW+1)'(1 << (GUARD - 1));
        lim  = (XW+1)'((1 << MAG_W) - 1);
        r    = (ext + half) >>> GUARD;
        if (r > lim)
            r = lim;
        else if (r < -lim)
            r = -lim;
        return r[MAG_W:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            phase_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            i_out_q <= '0;
            q_out_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_q   <= magnitude;
                        phase_q <= phase;
                        busy_q  <= 1'b1;
                        state_q <= PRESCALE;
                    end
                end
                PRESCALE: begin
                    // Coarse quadrant rotation; CORDIC then covers the remaining [0, pi/2).
                    case (phase_q[PHASE_W-1:PHASE_W-2])
                        2'd0:    begin x_q <= m_s;  y_q <= '0;   end
                        2'd1:    begin x_q <= '0;   y_q <= m_s;  end
                        2'd2:    begin x_q <= -m_s; y_q <= '0;   end
                        default: begin x_q <= '0;   y_q <= -m_s; end
                    endcase
                    z_q     <= ZW'({2'b00, phase_q[PHASE_W-3:0]});
                    iter_q  <= '0;
                    state_q <= ROTATE;
                end
                ROTATE: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (iter_q == IW'(ITER - 1)) begin
                        i_out_q <= round_sat(x_d);
                        q_out_q <= round_sat(y_d);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        iter_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        iter_q <= iter_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_out = i_out_q;
    assign q_out = q_out_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_polar_iq_modulator.sv
// tb/tb_polar_iq_modulator.sv - self-checking bench for polar_iq_modulator
module tb_polar_iq_modulator;

    localparam int ITER = 12;
    localparam int LAT  = ITER + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [8:0]        magnitude = '0;
    logic [15:0]       phase = '0;
    logic signed [9:0] i_out, q_out;
    logic              busy, valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    polar_iq_modulator #(.MAG_W(9), .PHASE_W(16), .ITER(ITER), .GUARD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .magnitude (magnitude),
        .phase     (phase),
        .i_out     (i_out),
        .q_out     (q_out),
        .busy      (busy),
        .valid     (valid)
    );

    task automatic check(input string tag, input int got, input int exp, input int tol);
        total++;
        if ((got - exp) > tol || (exp - got) > tol) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    // Ideal real-valued polar to rectangular conversion, rounded half up.
    function automatic int model(input int mag, input int ph, input bit want_q);
        real a, v;
        int  r;
        a = 2.0 * 3.14159265358979 * real'(ph) / 65536.0;
        v = want_q ? real'(mag) * $sin(a) : real'(mag) * $cos(a);
        r = int'($floor(v + 0.5));
        if (r > 511)  r = 511;
        if (r < -511) r = -511;
        return r;
    endfunction

    // Issues one request (optionally in the current negedge slot) and waits for valid.
    // lat = number of edges after the accepting edge at which valid is seen.
    task automatic run_req(input int mag, input int ph, input bit chained,
                           output int gi, output int gq, output int lat, output int b0);
        if (!chained) @(negedge clk);
        start     = 1'b1;
        magnitude = 9'(mag);
        phase     = 16'(ph);
        lat = -1;
        b0  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                b0    = int'(busy);
            end
            if (valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("timeout", 0, 1, 0);
        gi = int'(i_out);
        gq = int'(q_out);
    endtask

    typedef struct { int mag; int ph; int tol; } vec_t;

    initial begin
        int gi, gq, lat, b0, nval, m, p;
        vec_t dir [6];
        dir[0] = '{256, 'h0000, 1};
        dir[1] = '{256, 'h4000, 1};
        dir[2] = '{400, 'h2000, 2};
        dir[3] = '{511, 'h8000, 2};
        dir[4] = '{511, 'hC000, 2};
        dir[5] = '{0,   'h5A5A, 0};

        repeat (3) @(negedge clk);
        check("rst_i",     int'(i_out), 0, 0);
        check("rst_q",     int'(q_out), 0, 0);
        check("rst_busy",  int'(busy),  0, 0);
        check("rst_valid", int'(valid), 0, 0);
        rst = 1'b0;

        foreach (dir[n]) begin
            run_req(dir[n].mag, dir[n].ph, 1'b0, gi, gq, lat, b0);
            check("dir_i",   gi,  model(dir[n].mag, dir[n].ph, 1'b0), dir[n].tol);
            check("dir_q",   gq,  model(dir[n].mag, dir[n].ph, 1'b1), dir[n].tol);
            check("dir_lat", lat, LAT, 0);
            check("dir_busy", b0, 1, 0);
            @(negedge clk);
            check("pulse_len",  int'(valid), 0, 0);
            check("hold_i",     int'(i_out), gi, 0);
            check("busy_clear", int'(busy),  0, 0);
        end

        // Back-to-back: next start raised during the valid cycle.
        run_req(300, 'h1234, 1'b0, gi, gq, lat, b0);
        run_req(450, 'hB000, 1'b1, gi, gq, lat, b0);
        check("b2b_lat", lat, LAT, 0);
        check("b2b_i",   gi,  model(450, 'hB000, 1'b0), 2);
        check("b2b_q",   gq,  model(450, 'hB000, 1'b1), 2);

        // Start pulses while busy must be ignored.
        @(negedge clk);
        start = 1'b1; magnitude = 9'd333; phase = 16'h6000;
        nval = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 9) begin
                start = 1'b1; magnitude = 9'(100 + k); phase = 16'(k * 4000);
            end else begin
                start = 1'b0;
            end
            if (valid) begin
                nval++;
                check("ign_lat", k, LAT, 0);
                check("ign_i", int'(i_out), model(333, 'h6000, 1'b0), 2);
                check("ign_q", int'(q_out), model(333, 'h6000, 1'b1), 2);
            end
        end
        check("ign_count", nval, 1, 0);

        // Reset in ROTATE step 5 aborts the request.
        @(negedge clk);
        start = 1'b1; magnitude = 9'd300; phase = 16'h1800;
        nval = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 6) rst = 1'b1;
            if (k == 7) begin
                check("abort_i",     int'(i_out), 0, 0);
                check("abort_q",     int'(q_out), 0, 0);
                check("abort_busy",  int'(busy),  0, 0);
                check("abort_valid", int'(valid), 0, 0);
                rst = 1'b0;
            end
            if (valid) nval++;
        end
        check("abort_noval", nval, 0, 0);
        run_req(300, 'h1800, 1'b0, gi, gq, lat, b0);
        check("post_rst_lat", lat, LAT, 0);
        check("post_rst_i",   gi,  model(300, 'h1800, 1'b0), 2);
        check("post_rst_q",   gq,  model(300, 'h1800, 1'b1), 2);

        // Random sweep against the real-valued model.
        for (int n = 0; n < 40; n++) begin
            m = int'($urandom_range(0, 511));
            p = int'($urandom_range(0, 65535));
            run_req(m, p, 1'b0, gi, gq, lat, b0);
            check("rnd_i",   gi,  model(m, p, 1'b0), 2);
            check("rnd_q",   gq,  model(m, p, 1'b1), 2);
            check("rnd_lat", lat, LAT, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
